// File: rtl/icache_axi_rd_bridge_if.sv
// AXI4 read-address and read-data channels between the I-cache refill bridge
// (master) and the SoC arbiter/crossbar (slave).
interface icache_axi_rd_bridge_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int ID_WIDTH       = 4
);
   logic                      arvalid;
   logic                      arready;
   logic [ADDR_WIDTH-1:0]     araddr;
   logic [ID_WIDTH-1:0]       arid;
   logic [7:0]                arlen;
   logic [2:0]                arsize;
   logic [1:0]                arburst;
   logic                      rvalid;
   logic                      rready;
   logic [AXI_DATA_WIDTH-1:0] rdata;
   logic [1:0]                rresp;
   logic                      rlast;
   logic [ID_WIDTH-1:0]       rid;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rdata, rresp, rlast, rid
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// I-cache line-refill responder: turns one refill request into a single AXI4
// INCR read burst and returns each 32-bit word as a one-cycle beat pulse.
module icache_axi_rd_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int ID_WIDTH       = 4,
   parameter int AXI_ID         = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [7:0]            req_len_i,
   output logic                  rsp_ready_o,
   output logic [DATA_WIDTH-1:0] rsp_data_o,
   output logic                  rsp_last_o,
   output logic                  rsp_err_o,
   icache_axi_rd_bridge_if.master axi
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_DONE
   } state_t;

   state_t     state;
   logic [7:0] cnt;
   // Selects the 32-bit lane of the 64-bit R beat; equals bit 2 of the
   // running beat address, which toggles every word.
   logic       lane_hi;

   // The ID is constant and the bridge has a single outstanding burst, so rid
   // carries no information here.
   logic       unused_rid;
   assign unused_rid = ^axi.rid;

   // Refill sequencer: request latch, AR issue, R beat forwarding, DONE guard.
   always_ff @(posedge clock) begin
      // NOTE: every register here, including the request latch, is cleared by
      // the synchronous reset so an aborted burst leaves no stale fields behind.
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         lane_hi     <= 1'b0;
         rsp_ready_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_last_o  <= 1'b0;
         rsp_err_o   <= 1'b0;
         axi.arvalid <= 1'b0;
         axi.araddr  <= '0;
         axi.arid    <= '0;
         axi.arlen   <= '0;
         axi.arsize  <= '0;
         axi.arburst <= '0;
         axi.rready  <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults make the response strobes one-cycle
         // pulses; the case below only overrides them on an R handshake.
         rsp_ready_o <= 1'b0;
         rsp_last_o  <= 1'b0;
         rsp_err_o   <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  axi.araddr  <= req_addr_i;
                  axi.arlen   <= req_len_i;
                  axi.arid    <= ID_WIDTH'(AXI_ID);
                  axi.arsize  <= 3'b010;
                  axi.arburst <= 2'b01;
                  axi.arvalid <= 1'b1;
                  lane_hi     <= req_addr_i[2];
                  cnt         <= '0;
                  state       <= ST_AR;
               end
            end
            ST_AR: begin
               if (axi.arready) begin
                  axi.arvalid <= 1'b0;
                  axi.rready  <= 1'b1;
                  state       <= ST_R;
               end
            end
            ST_R: begin
               if (axi.rvalid && axi.rready) begin
                  rsp_ready_o <= 1'b1;
                  rsp_data_o  <= lane_hi ? axi.rdata[DATA_WIDTH +: DATA_WIDTH]
                                         : axi.rdata[0 +: DATA_WIDTH];
                  rsp_last_o  <= axi.rlast;
                  rsp_err_o   <= (axi.rresp != 2'b00) | (axi.rlast != (cnt == axi.arlen));
                  lane_hi     <= ~lane_hi;
                  cnt         <= cnt + 8'd1;
                  if (axi.rlast) begin
                     axi.rready <= 1'b0;
                     state      <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               // The cache still holds req_valid_i while it sees rsp_last_o;
               // spending this cycle here keeps that from re-issuing the line.
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Bench for icache_axi_rd_bridge: directed refill bursts against a
// transaction-level model of the response stream.
module tb_icache_axi_rd_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid_i = 1'b0;
   logic [31:0] req_addr_i  = '0;
   logic [7:0]  req_len_i   = '0;
   logic        rsp_ready_o;
   logic [31:0] rsp_data_o;
   logic        rsp_last_o;
   logic        rsp_err_o;

   icache_axi_rd_bridge_if bus ();

   icache_axi_rd_bridge dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid_i (req_valid_i),
      .req_addr_i  (req_addr_i),
      .req_len_i   (req_len_i),
      .rsp_ready_o (rsp_ready_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_last_o  (rsp_last_o),
      .rsp_err_o   (rsp_err_o),
      .axi         (bus.master)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: burst address, beat count and whether the R phase is open.
   bit          m_in_r = 1'b0;
   logic [31:0] m_addr = '0;
   logic [7:0]  m_len  = '0;
   int          m_cnt  = 0;
   bit          exp_ready = 1'b0, exp_last = 1'b0, exp_err = 1'b0;
   logic [31:0] exp_data = '0;
   bit          cmp_en = 1'b0;
   logic [31:0] obs_data[$];
   bit          obs_last[$];
   bit          obs_err[$];

   // Model: each accepted R beat yields the addressed word one cycle later.
   always @(posedge clock) begin
      if (reset) begin
         exp_ready = 1'b0; exp_last = 1'b0; exp_err = 1'b0;
         m_in_r = 1'b0;
      end else if (m_in_r && bus.rvalid) begin
         exp_ready = 1'b1;
         exp_data  = (m_addr % 8 == 4) ? bus.rdata[63:32] : bus.rdata[31:0];
         exp_last  = bus.rlast;
         exp_err   = (bus.rresp != 2'b00) || (bus.rlast != (m_cnt == int'(m_len)));
         m_addr    = m_addr + 32'd4;
         m_cnt     = m_cnt + 1;
         if (bus.rlast) m_in_r = 1'b0;
      end else begin
         exp_ready = 1'b0; exp_last = 1'b0; exp_err = 1'b0;
      end
   end

   // Compare: response outputs against the model on every cycle.
   always @(negedge clock) begin
      if (cmp_en) begin
         check("rsp_ready", rsp_ready_o, exp_ready);
         check("rsp_last", rsp_last_o, exp_last);
         check("rsp_err", rsp_err_o, exp_err);
         if (exp_ready) check("rsp_data", rsp_data_o, exp_data);
         if (rsp_ready_o) begin
            obs_data.push_back(rsp_data_o);
            obs_last.push_back(rsp_last_o);
            obs_err.push_back(rsp_err_o);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [63:0] beat_data(input int t, input int k);
      logic [31:0] lo, hi;
      lo = 32'hA000_0000 + 32'(t * 256 + k);
      hi = 32'hB000_0000 + 32'(t * 256 + k);
      return {hi, lo};
   endfunction

   task automatic clear_obs();
      obs_data.delete();
      obs_last.delete();
      obs_err.delete();
   endtask

   task automatic send_req(input logic [31:0] a, input logic [7:0] l);
      req_valid_i = 1'b1;
      req_addr_i  = a;
      req_len_i   = l;
      m_addr      = a;
      m_len       = l;
      m_cnt       = 0;
      step();
   endtask

   // Holds arready low for dly cycles, then accepts; req fields are scrambled
   // mid-phase to show the latched AR fields do not follow them.
   task automatic ar_phase(input int dly, input logic [31:0] a, input logic [7:0] l);
      int hi = 0;
      for (int i = 0; i <= dly; i++) begin
         bus.arready = (i == dly);
         if (i == 1) begin
            req_addr_i = 32'hDEAD_BEE0;
            req_len_i  = 8'h55;
         end
         @(negedge clock);
         check("arvalid", bus.arvalid, 1'b1);
         check("araddr", bus.araddr, a);
         check("arlen", bus.arlen, l);
         check("arsize", bus.arsize, 3'b010);
         check("arburst", bus.arburst, 2'b01);
         check("arid", bus.arid, 4'd0);
         if (bus.arvalid) hi++;
         step();
      end
      bus.arready = 1'b0;
      m_in_r = 1'b1;
      check("ar_cycles", hi, dly + 1);
      @(negedge clock);
      check("arvalid_after_hs", bus.arvalid, 1'b0);
      check("rready_in_r", bus.rready, 1'b1);
   endtask

   task automatic r_beat(input bit v, input logic [63:0] d, input logic [1:0] resp, input bit last);
      bus.rvalid = v;
      bus.rdata  = d;
      bus.rresp  = resp;
      bus.rlast  = last;
      step();
      bus.rvalid = 1'b0;
      bus.rresp  = 2'b00;
      bus.rlast  = 1'b0;
   endtask

   // Called in the DONE cycle; req_valid_i stays high through it, then drops.
   task automatic finish_burst();
      @(negedge clock);
      check("done_arvalid", bus.arvalid, 1'b0);
      check("done_rready", bus.rready, 1'b0);
      step();
      req_valid_i = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("idle_arvalid", bus.arvalid, 1'b0);
         check("idle_rready", bus.rready, 1'b0);
         step();
      end
   endtask

   initial begin
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rdata   = '0;
      bus.rresp   = 2'b00;
      bus.rlast   = 1'b0;
      bus.rid     = '0;

      // Reset state
      step();
      step();
      cmp_en = 1'b1;
      @(negedge clock);
      check("rst_arvalid", bus.arvalid, 1'b0);
      check("rst_rready", bus.rready, 1'b0);
      check("rst_araddr", bus.araddr, 32'h0);
      check("rst_arsize", bus.arsize, 3'b000);
      check("rst_rsp_data", rsp_data_o, 32'h0);
      reset = 1'b0;
      step();

      // T1: immediate arready, back-to-back beats, alternating lanes
      clear_obs();
      send_req(32'h3000_0010, 8'd3);
      ar_phase(0, 32'h3000_0010, 8'd3);
      for (int k = 0; k < 4; k++) r_beat(1'b1, beat_data(1, k), 2'b00, k == 3);
      finish_burst();
      check("t1_count", obs_data.size(), 4);
      if (obs_data.size() == 4) begin
         check("t1_w0", obs_data[0], 32'hA000_0100);
         check("t1_w1", obs_data[1], 32'hB000_0101);
         check("t1_w2", obs_data[2], 32'hA000_0102);
         check("t1_w3", obs_data[3], 32'hB000_0103);
         check("t1_last", {obs_last[0], obs_last[1], obs_last[2], obs_last[3]}, 4'b0001);
      end

      // T2: arready delayed five cycles
      clear_obs();
      send_req(32'h4000_0020, 8'd3);
      ar_phase(5, 32'h4000_0020, 8'd3);
      for (int k = 0; k < 4; k++) r_beat(1'b1, beat_data(2, k), 2'b00, k == 3);
      finish_burst();
      check("t2_count", obs_data.size(), 4);

      // T3: rvalid gaps 1,0,0,1,1,0,1
      begin
         bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
         int k = 0;
         clear_obs();
         send_req(32'h1000_0000, 8'd3);
         ar_phase(0, 32'h1000_0000, 8'd3);
         for (int i = 0; i < 7; i++) begin
            r_beat(pat[i], beat_data(3, k), 2'b00, pat[i] && (k == 3));
            if (pat[i]) k++;
         end
         finish_burst();
         check("t3_count", obs_data.size(), 4);
         if (obs_data.size() == 4) check("t3_w3", obs_data[3], 32'hB000_0303);
      end

      // T5a: SLVERR-style response on beat 2 only
      clear_obs();
      send_req(32'h2000_0040, 8'd3);
      ar_phase(1, 32'h2000_0040, 8'd3);
      for (int k = 0; k < 4; k++)
         r_beat(1'b1, beat_data(4, k), (k == 2) ? 2'b10 : 2'b00, k == 3);
      finish_burst();
      if (obs_err.size() == 4)
         check("t5a_err", {obs_err[0], obs_err[1], obs_err[2], obs_err[3]}, 4'b0010);
      else
         check("t5a_count", obs_err.size(), 4);

      // T5b: early rlast on the first beat of a 4-beat burst
      clear_obs();
      send_req(32'h2000_0080, 8'd3);
      ar_phase(0, 32'h2000_0080, 8'd3);
      r_beat(1'b1, beat_data(5, 0), 2'b00, 1'b1);
      finish_burst();
      check("t5b_count", obs_data.size(), 1);
      if (obs_data.size() == 1) begin
         check("t5b_last", obs_last[0], 1'b1);
         check("t5b_err", obs_err[0], 1'b1);
      end

      // len=0 single-beat burst
      clear_obs();
      send_req(32'h7000_0000, 8'd0);
      ar_phase(0, 32'h7000_0000, 8'd0);
      r_beat(1'b1, beat_data(6, 0), 2'b00, 1'b1);
      finish_burst();
      check("len0_count", obs_data.size(), 1);
      if (obs_data.size() == 1) begin
         check("len0_data", obs_data[0], 32'hA000_0600);
         check("len0_last", obs_last[0], 1'b1);
         check("len0_err", obs_err[0], 1'b0);
      end

      // T6: reset after two beats, then a fresh request
      clear_obs();
      send_req(32'h5000_0000, 8'd3);
      ar_phase(1, 32'h5000_0000, 8'd3);
      r_beat(1'b1, beat_data(7, 0), 2'b00, 1'b0);
      r_beat(1'b1, beat_data(7, 1), 2'b00, 1'b0);
      reset = 1'b1;
      req_valid_i = 1'b0;
      step();
      @(negedge clock);
      check("t6_arvalid", bus.arvalid, 1'b0);
      check("t6_rready", bus.rready, 1'b0);
      check("t6_rsp_ready", rsp_ready_o, 1'b0);
      check("t6_rsp_last", rsp_last_o, 1'b0);
      check("t6_rsp_data", rsp_data_o, 32'h0);
      step();
      reset = 1'b0;
      step();
      clear_obs();
      send_req(32'h6000_0010, 8'd0);
      ar_phase(0, 32'h6000_0010, 8'd0);
      r_beat(1'b1, beat_data(8, 0), 2'b00, 1'b1);
      finish_burst();
      check("t6_new_count", obs_data.size(), 1);
      if (obs_data.size() == 1) check("t6_new_data", obs_data[0], 32'hA000_0800);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
